// File: rtl/matrix_mac_sequencer.sv
// Memory-side master computing C = A x B for NxN 32-bit row-major matrices.
// Owns the data-memory port while busy, issuing exactly one access per cycle:
// for each C element, N interleaved A/B reads followed by one C write.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      one-cycle request, honoured only in IDLE
//   mem_rdata  memory read data (combinational from mem_addr/mem_read)
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   mem_addr   17-bit byte address
//   mem_wdata  memory write data
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last C element is written
module matrix_mac_sequencer #(
  parameter int unsigned N      = 3,
  parameter logic [16:0] A_BASE = 17'h00200,
  parameter logic [16:0] B_BASE = 17'h00300,
  parameter logic [16:0] C_BASE = 17'h00100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

  state_t        state;
  logic [CW-1:0] i;
  logic [CW-1:0] j;
  logic [CW-1:0] k;
  logic [31:0]   acc;
  logic [31:0]   a_reg;
  logic [31:0]   acc_sum_c;

  // Running dot product including the B element being read this cycle (wraps mod 2^32).
  assign acc_sum_c = acc + a_reg * mem_rdata;

  // Byte address of element [row][col] in a row-major matrix at base.
  function automatic logic [16:0] elem_addr(input logic [16:0] base,
                                            input logic [CW-1:0] row,
                                            input logic [CW-1:0] col);
    return base + ((17'(N) * 17'(row) + 17'(col)) << 2);
  endfunction

  // Outputs are registered: each transition loads the outputs of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      a_reg     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            state    <= RD_A;
            mem_read <= 1'b1;
            mem_addr <= A_BASE;
            busy     <= 1'b1;
          end
        end

        RD_A: begin
          a_reg    <= mem_rdata;
          state    <= RD_B;
          mem_addr <= elem_addr(B_BASE, k, j);
        end

        RD_B: begin
          acc <= acc_sum_c;
          if (k == LAST) begin
            state     <= WR;
            mem_read  <= 1'b0;
            mem_write <= 1'b1;
            mem_addr  <= elem_addr(C_BASE, i, j);
            mem_wdata <= acc_sum_c;
          end else begin
            k        <= k + CW'(1);
            state    <= RD_A;
            mem_addr <= elem_addr(A_BASE, i, k + CW'(1));
          end
        end

        WR: begin
          acc       <= '0;
          k         <= '0;
          mem_write <= 1'b0;
          mem_wdata <= '0;
          if (j != LAST) begin
            j        <= j + CW'(1);
            state    <= RD_A;
            mem_read <= 1'b1;
            mem_addr <= elem_addr(A_BASE, i, '0);
          end else if (i != LAST) begin
            j        <= '0;
            i        <= i + CW'(1);
            state    <= RD_A;
            mem_read <= 1'b1;
            mem_addr <= elem_addr(A_BASE, i + CW'(1), '0);
          end else begin
            state    <= DONE;
            mem_addr <= '0;
            done     <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
